// File: rtl/rvfi_check_sequencer.sv
// Fires a single-shot check strobe when the target instruction order retires on any
// RVFI channel inside the legal cycle window, and keeps sticky fired/missed/timeout status.
module rvfi_check_sequencer #(
  parameter int NRET       = 1,
  parameter int MIN_CYCLES = 5,
  parameter int MAX_CYCLES = 30,
  parameter int REQ_PRED   = 1,
  parameter int CNT_W      = 8,
  localparam int CHAN_W    = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NRET-1:0]       rvfi_valid,
  input  logic [64*NRET-1:0]    rvfi_order,
  input  logic [63:0]           target_order,
  output logic                  check,
  output logic [CHAN_W-1:0]     check_chan,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic                  fired,
  output logic                  missed,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DONE,
    MISSED,
    TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  state_t              state;
  logic                pred_seen;
  logic [63:0]         pred_order;
  logic                match;
  logic [CHAN_W-1:0]   match_chan;
  logic                pred_lower;
  logic                pred_before;
  logic                pred_ok;
  logic                in_window;

  // Target-1 with natural 64-bit wrap, so target 0 expects 2^64-1 as predecessor.
  assign pred_order = target_order - 64'd1;

  // Scan channels in ascending order: the first target hit wins, and only
  // predecessor hits on strictly lower channels count as "retired before".
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    match       = 1'b0;
    match_chan  = '0;
    pred_lower  = 1'b0;
    pred_before = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i] && (rvfi_order[64*i +: 64] == target_order) && !match) begin
        match       = 1'b1;
        match_chan  = CHAN_W'(i);
        pred_before = pred_lower;
      end
      if (rvfi_valid[i] && (rvfi_order[64*i +: 64] == pred_order)) begin
        pred_lower = 1'b1;
      end
    end
  end

  assign pred_ok   = (REQ_PRED == 0) || pred_seen || pred_before;
  assign in_window = (cycle_cnt >= MIN_C);

  // Zero-latency strobe; it depends on registered state so reset kills it at once.
  assign check      = (state == WAIT) && match && in_window && pred_ok;
  assign check_chan = check ? match_chan : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      pred_seen <= 1'b0;
      fired     <= 1'b0;
      missed    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (((state == IDLE) || (state == WAIT)) && (cycle_cnt != MAX_C)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          if (pred_lower) begin
            pred_seen <= 1'b1;
          end
          if (match) begin
            if (in_window && pred_ok) begin
              state <= DONE;
              fired <= 1'b1;
            end else begin
              state  <= MISSED;
              missed <= 1'b1;
            end
          end else if (cycle_cnt == MAX_C) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench for rvfi_check_sequencer: one NRET=1 and one NRET=2 instance on shared
// stimulus, expected strobe/channel/count queued per step and compared mid-cycle.
module tb_rvfi_check_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   valid = '0;
  logic [127:0] order = '0;
  logic [63:0]  target = 64'd7;

  logic         check1, check2;
  logic [0:0]   chan1, chan2;
  logic [7:0]   cnt1, cnt2;
  logic         fired1, missed1, timeout1;
  logic         fired2, missed2, timeout2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_cnt = '0;
  bit         term = 1'b0;

  typedef struct {
    logic       chk;
    logic [0:0] chan;
    logic [7:0] cnt;
    bit         dual;
  } exp_t;
  exp_t sb[$];

  localparam logic [63:0] ONES = '1;

  always #5 clk = ~clk;

  rvfi_check_sequencer #(.NRET(1)) u_n1 (
    .clock(clk), .reset(rst), .rvfi_valid(valid[0:0]), .rvfi_order(order[63:0]),
    .target_order(target), .check(check1), .check_chan(chan1), .cycle_cnt(cnt1),
    .fired(fired1), .missed(missed1), .timeout(timeout1)
  );

  rvfi_check_sequencer #(.NRET(2)) u_n2 (
    .clock(clk), .reset(rst), .rvfi_valid(valid), .rvfi_order(order),
    .target_order(target), .check(check2), .check_chan(chan2), .cycle_cnt(cnt2),
    .fired(fired2), .missed(missed2), .timeout(timeout2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at +1 after posedge, compare at the following negedge.
  task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                      input logic e_chk, input logic e_chan, input bit dual, input bit ends);
    exp_t e;
    valid = v;
    order = {o1, o0};
    e.chk = e_chk; e.chan = e_chan; e.cnt = exp_cnt; e.dual = dual;
    sb.push_back(e);
    #4;
    e = sb.pop_front();
    check("check", {63'd0, check2}, {63'd0, e.chk});
    check("check_chan", {63'd0, chan2}, {63'd0, e.chan});
    check("cycle_cnt", {56'd0, cnt2}, {56'd0, e.cnt});
    if (e.dual) begin
      check("n1_check", {63'd0, check1}, {63'd0, e.chk});
      check("n1_cycle_cnt", {56'd0, cnt1}, {56'd0, e.cnt});
    end
    @(posedge clk);
    #1;
    valid = '0;
    if (!term && exp_cnt != 8'd30) exp_cnt++;
    if (ends) term = 1'b1;
  endtask

  task automatic idle_to(input logic [7:0] n, input bit dual);
    while (exp_cnt < n) step(2'b00, 64'd0, 64'd0, 1'b0, 1'b0, dual, 1'b0);
  endtask

  task automatic status(input string tag, input logic f, input logic m, input logic t);
    check({tag, "_fired"}, {63'd0, fired2}, {63'd0, f});
    check({tag, "_missed"}, {63'd0, missed2}, {63'd0, m});
    check({tag, "_timeout"}, {63'd0, timeout2}, {63'd0, t});
  endtask

  task automatic do_reset(input logic [63:0] tgt);
    rst = 1'b1;
    valid = '0;
    target = tgt;
    @(posedge clk);
    #1;
    check("rst_check", {63'd0, check2}, 64'd0);
    check("rst_cnt", {56'd0, cnt2}, 64'd0);
    status("rst", 1'b0, 1'b0, 1'b0);
    sb.delete();
    rst = 1'b0;
    exp_cnt = '0;
    term = 1'b0;
  endtask

  task automatic scen1();
    do_reset(64'd7);
    idle_to(8'd6, 1'b1);
    step(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2'b01, 64'd7, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(2'b01, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    status("s1", 1'b1, 1'b0, 1'b0);
    check("s1_n1_fired", {63'd0, fired1}, 64'd1);
    check("s1_cnt_frozen", {56'd0, cnt2}, 64'd9);
  endtask

  initial begin
    // Predecessor then target on a single channel.
    scen1();

    // Predecessor on lower channel in the same cycle counts; on higher channel it does not.
    do_reset(64'd7);
    idle_to(8'd9, 1'b0);
    step(2'b11, 64'd6, 64'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    status("s2a", 1'b1, 1'b0, 1'b0);
    do_reset(64'd7);
    idle_to(8'd9, 1'b0);
    step(2'b11, 64'd7, 64'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    status("s2b", 1'b0, 1'b1, 1'b0);

    // Target before the window opens.
    do_reset(64'd7);
    idle_to(8'd2, 1'b0);
    step(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'b01, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    status("s3", 1'b0, 1'b1, 1'b0);
    check("s3_cnt_frozen", {56'd0, cnt2}, 64'd4);

    // Target never retires.
    do_reset(64'd7);
    idle_to(8'd30, 1'b0);
    step(2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'b01, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    status("s4", 1'b0, 1'b0, 1'b1);
    check("s4_cnt_sat", {56'd0, cnt2}, 64'd30);

    // Target on the last in-window cycle.
    do_reset(64'd7);
    idle_to(8'd10, 1'b0);
    step(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(8'd30, 1'b0);
    step(2'b01, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    status("s5", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-window while check is high, then a full rerun.
    do_reset(64'd7);
    idle_to(8'd6, 1'b0);
    step(2'b01, 64'd6, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(8'd12, 1'b0);
    valid = 2'b01;
    order = {64'd0, 64'd7};
    #2;
    check("s6_check_pre", {63'd0, check2}, 64'd1);
    rst = 1'b1;
    #1;
    check("s6_check_async", {63'd0, check2}, 64'd0);
    check("s6_cnt_async", {56'd0, cnt2}, 64'd0);
    status("s6", 1'b0, 1'b0, 1'b0);
    scen1();

    // Target 0: predecessor wraps to all-ones.
    do_reset(64'd0);
    idle_to(8'd5, 1'b0);
    step(2'b11, ONES, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    status("s7", 1'b1, 1'b0, 1'b0);

    // Duplicate target on both channels: lowest index wins.
    do_reset(64'd7);
    idle_to(8'd5, 1'b0);
    step(2'b10, 64'd0, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 64'd7, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    status("s8", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
